// File: rtl/fft4_seq_engine.sv
// fft4_seq_engine: sequential 4-point radix-2 DIT FFT with one shared butterfly
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        transform request, honoured only while idle
//   samples[0:3] time-domain inputs x0..x3, {re[7:0], im[7:0]} signed
//   freqs[0:3]   registered bins X0..X3 scaled by 1/4, same packed format
//   done         one-cycle pulse in the cycle freqs has just been updated
//   busy         high from acceptance through the done cycle
module fft4_seq_engine (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] samples [0:3],
    output logic [15:0] freqs [0:3],
    output logic        done,
    output logic        busy
);
    typedef enum logic [2:0] {IDLE, S1A, S1B, S2A, S2B, DONE} state_t;
    state_t state;
    // Working registers are reused in place: after S1A slots 0/2 hold a0/a1,
    // after S1B slots 1/3 hold b0/b1, after S2A slots 0/1 hold X0/X2.
    logic signed [9:0] re [0:3];
    logic signed [9:0] im [0:3];
    logic signed [9:0] p_re, p_im, q_re, q_im, s_re, s_im, d_re, d_im;
    function automatic logic [15:0] pack(input logic signed [9:0] r, input logic signed [9:0] i);
        return {r[9:2], i[9:2]};
    endfunction
    // Butterfly operand select; in S2B q is b1 rotated by -j so the sum is X1
    // and the difference is X3.
    always_comb begin
        p_re = re[0];
        p_im = im[0];
        q_re = re[2];
        q_im = im[2];
        case (state)
            S1B: begin
                p_re = re[1];
                p_im = im[1];
                q_re = re[3];
                q_im = im[3];
            end
            S2A: begin
                q_re = re[1];
                q_im = im[1];
            end
            S2B: begin
                p_re = re[2];
                p_im = im[2];
                q_re = im[3];
                q_im = -re[3];
            end
            default: ;
        endcase
        s_re = p_re + q_re;
        s_im = p_im + q_im;
        d_re = p_re - q_re;
        d_im = p_im - q_im;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            done  <= 1'b0;
            busy  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                re[i]    <= '0;
                im[i]    <= '0;
                freqs[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        for (int i = 0; i < 4; i++) begin
                            re[i] <= {{2{samples[i][15]}}, samples[i][15:8]};
                            im[i] <= {{2{samples[i][7]}}, samples[i][7:0]};
                        end
                        busy  <= 1'b1;
                        state <= S1A;
                    end
                end
                S1A: begin
                    re[0] <= s_re;
                    im[0] <= s_im;
                    re[2] <= d_re;
                    im[2] <= d_im;
                    state <= S1B;
                end
                S1B: begin
                    re[1] <= s_re;
                    im[1] <= s_im;
                    re[3] <= d_re;
                    im[3] <= d_im;
                    state <= S2A;
                end
                S2A: begin
                    re[0] <= s_re;
                    im[0] <= s_im;
                    re[1] <= d_re;
                    im[1] <= d_im;
                    state <= S2B;
                end
                S2B: begin
                    freqs[0] <= pack(re[0], im[0]);
                    freqs[1] <= pack(s_re, s_im);
                    freqs[2] <= pack(re[1], im[1]);
                    freqs[3] <= pack(d_re, d_im);
                    done     <= 1'b1;
                    state    <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fft4_seq_engine.sv
// tb_fft4_seq_engine: randomized and directed self-checking bench for fft4_seq_engine
module tb_fft4_seq_engine;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] samples [0:3];
    logic [15:0] freqs [0:3];
    logic        done;
    logic        busy;
    int checks = 0;
    int errors = 0;

    fft4_seq_engine dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .samples(samples),
        .freqs(freqs),
        .done(done),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Direct DFT: X_k = sum_n x_n * (-j)^(n*k), then floor-divide by 4.
    function automatic logic [15:0] ref_bin(input logic [15:0] w [0:3], input int k);
        int sr, si, r, i, t;
        sr = 0;
        si = 0;
        for (int n = 0; n < 4; n++) begin
            r = $signed(w[n][15:8]);
            i = $signed(w[n][7:0]);
            for (int q = 0; q < (n * k) % 4; q++) begin
                t = r;
                r = i;
                i = -t;
            end
            sr += r;
            si += i;
        end
        sr = sr >>> 2;
        si = si >>> 2;
        return {sr[7:0], si[7:0]};
    endfunction

    // Runs one transform from idle; reports bins, latency to done, busy cycles
    // and the done/busy levels one cycle after done.
    task automatic xform(input logic [15:0] w [0:3], output logic [15:0] got [0:3],
                         output int lat, output int bh, output logic d2, output logic b2);
        @(negedge clk);
        samples = w;
        start = 1'b1;
        @(posedge clk);
        lat = 0;
        bh = 0;
        @(negedge clk);
        start = 1'b0;
        while (!done && lat < 20) begin
            if (busy) bh++;
            @(negedge clk);
            lat++;
        end
        if (busy) bh++;
        got = freqs;
        @(negedge clk);
        d2 = done;
        b2 = busy;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (freqs[k] !== 16'h0000) begin
                errors++;
                $display("FAIL reset_freqs[%0d] got %h want 0000", k, freqs[k]);
            end
        end
        checks++;
        if ({done, busy} !== 2'b00) begin
            errors++;
            $display("FAIL reset_flags got done=%b busy=%b want 0 0", done, busy);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed;
        logic [15:0] vin [7][0:3];
        logic [15:0] vexp [7][0:3];
        logic [15:0] w [0:3];
        logic [15:0] got [0:3];
        int lat, bh;
        logic d2, b2;
        vin[0] = '{16'h4000, 16'h0000, 16'h0000, 16'h0000};
        vexp[0] = '{16'h1000, 16'h1000, 16'h1000, 16'h1000};
        vin[1] = '{16'h2000, 16'h2000, 16'h2000, 16'h2000};
        vexp[1] = '{16'h2000, 16'h0000, 16'h0000, 16'h0000};
        vin[2] = '{16'h2000, 16'hE000, 16'h2000, 16'hE000};
        vexp[2] = '{16'h0000, 16'h0000, 16'h2000, 16'h0000};
        vin[3] = '{16'h0000, 16'h2000, 16'h0000, 16'hE000};
        vexp[3] = '{16'h0000, 16'h00F0, 16'h0000, 16'h0010};
        vin[4] = '{16'hFF00, 16'h0000, 16'h0000, 16'h0000};
        vexp[4] = '{16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00};
        vin[5] = '{16'h0100, 16'h0000, 16'h0000, 16'h0000};
        vexp[5] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
        vin[6] = '{16'h0040, 16'h0000, 16'h0000, 16'h0000};
        vexp[6] = '{16'h0010, 16'h0010, 16'h0010, 16'h0010};
        for (int v = 0; v < 7; v++) begin
            w = vin[v];
            xform(w, got, lat, bh, d2, b2);
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (got[k] !== vexp[v][k]) begin
                    errors++;
                    $display("FAIL directed%0d_X%0d got %h want %h", v, k, got[k], vexp[v][k]);
                end
            end
            checks++;
            if (lat !== 4) begin
                errors++;
                $display("FAIL directed%0d_latency got %0d want 4", v, lat);
            end
            checks++;
            if (bh !== 5) begin
                errors++;
                $display("FAIL directed%0d_busy_cycles got %0d want 5", v, bh);
            end
            checks++;
            if ({d2, b2} !== 2'b00) begin
                errors++;
                $display("FAIL directed%0d_after_done got done=%b busy=%b want 0 0", v, d2, b2);
            end
        end
    endtask

    task automatic test_random;
        logic [15:0] w [0:3];
        logic [15:0] got [0:3];
        logic [15:0] e;
        int lat, bh;
        logic d2, b2;
        for (int t = 0; t < 40; t++) begin
            for (int k = 0; k < 4; k++) w[k] = 16'($urandom);
            xform(w, got, lat, bh, d2, b2);
            for (int k = 0; k < 4; k++) begin
                e = ref_bin(w, k);
                checks++;
                if (got[k] !== e) begin
                    errors++;
                    $display("FAIL random%0d_X%0d in %h %h %h %h got %h want %h",
                             t, k, w[0], w[1], w[2], w[3], got[k], e);
                end
            end
            checks++;
            if (lat !== 4 || d2 !== 1'b0) begin
                errors++;
                $display("FAIL random%0d_timing got lat=%0d done_after=%b want 4 0", t, lat, d2);
            end
        end
    endtask

    task automatic test_start_ignored;
        logic [15:0] w1 [0:3];
        logic [15:0] w2 [0:3];
        logic [15:0] got [0:3];
        logic [15:0] e;
        int nd;
        for (int k = 0; k < 4; k++) begin
            w1[k] = 16'($urandom);
            w2[k] = ~w1[k];
        end
        @(negedge clk);
        samples = w1;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        samples = w2;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nd = 0;
        got = freqs;
        for (int i = 0; i < 12; i++) begin
            if (done) begin
                nd++;
                got = freqs;
            end
            @(negedge clk);
        end
        checks++;
        if (nd !== 1) begin
            errors++;
            $display("FAIL start_ignored_done_count got %0d want 1", nd);
        end
        for (int k = 0; k < 4; k++) begin
            e = ref_bin(w1, k);
            checks++;
            if (got[k] !== e) begin
                errors++;
                $display("FAIL start_ignored_X%0d got %h want %h", k, got[k], e);
            end
        end
    endtask

    task automatic test_samples_change;
        logic [15:0] w1 [0:3];
        logic [15:0] got [0:3];
        logic [15:0] e;
        int lat;
        for (int k = 0; k < 4; k++) w1[k] = 16'($urandom);
        @(negedge clk);
        samples = w1;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 20) begin
            for (int k = 0; k < 4; k++) samples[k] = 16'($urandom);
            @(negedge clk);
            lat++;
        end
        got = freqs;
        checks++;
        if (lat !== 4) begin
            errors++;
            $display("FAIL samples_change_latency got %0d want 4", lat);
        end
        for (int k = 0; k < 4; k++) begin
            e = ref_bin(w1, k);
            checks++;
            if (got[k] !== e) begin
                errors++;
                $display("FAIL samples_change_X%0d got %h want %h", k, got[k], e);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        logic [15:0] w [0:3];
        logic [15:0] e;
        int at [$];
        for (int k = 0; k < 4; k++) w[k] = 16'($urandom);
        @(negedge clk);
        samples = w;
        start = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) begin
                at.push_back(i);
                for (int k = 0; k < 4; k++) begin
                    e = ref_bin(w, k);
                    checks++;
                    if (freqs[k] !== e) begin
                        errors++;
                        $display("FAIL back_to_back_X%0d at %0d got %h want %h", k, i, freqs[k], e);
                    end
                end
            end
        end
        start = 1'b0;
        checks++;
        if (at.size() !== 3) begin
            errors++;
            $display("FAIL back_to_back_count got %0d want 3", at.size());
        end
        for (int j = 1; j < at.size(); j++) begin
            checks++;
            if (at[j] - at[j-1] !== 6) begin
                errors++;
                $display("FAIL back_to_back_spacing%0d got %0d want 6", j, at[j] - at[j-1]);
            end
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        logic [15:0] w [0:3];
        logic [15:0] got [0:3];
        int lat, bh, nd;
        logic d2, b2;
        w = '{16'h4000, 16'h0000, 16'h0000, 16'h0000};
        @(negedge clk);
        samples = '{16'h7F7F, 16'h1234, 16'h8080, 16'h5555};
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({done, busy} !== 2'b00) begin
            errors++;
            $display("FAIL reset_mid_flags got done=%b busy=%b want 0 0", done, busy);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (freqs[k] !== 16'h0000) begin
                errors++;
                $display("FAIL reset_mid_freqs[%0d] got %h want 0000", k, freqs[k]);
            end
        end
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        nd = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done || freqs[0] !== 16'h0000) nd++;
        end
        checks++;
        if (nd !== 0) begin
            errors++;
            $display("FAIL reset_mid_no_done got %0d spurious cycles want 0", nd);
        end
        xform(w, got, lat, bh, d2, b2);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (got[k] !== 16'h1000) begin
                errors++;
                $display("FAIL reset_mid_impulse_X%0d got %h want 1000", k, got[k]);
            end
        end
        checks++;
        if (lat !== 4 || bh !== 5 || d2 !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_timing got lat=%0d busy=%0d done_after=%b want 4 5 0", lat, bh, d2);
        end
    endtask

    initial begin
        samples = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
        test_reset;
        test_directed;
        test_random;
        test_start_ignored;
        test_samples_change;
        test_back_to_back;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
